tt_fll_ctrl: RTL and testbench
==============================

Name: tt_fll_ctrl

Overview:
- Frequency-locked-loop controller; sits directly upstream of the ring-oscillator DCO.
- Counts DCO ticks over a fixed window of i_clk cycles and compares the count with a programmable target.
- Runs a saturating PI update on the error.
- Drives the DCO's signed 16-bit control word and enable. Control 0 = DCO mid-range, since the DCO offsets control by 0x8000.

Parameters:
- WINDOW_LOG2, 10, measurement window = 2^WINDOW_LOG2 i_clk cycles
- KP_SHIFT, 2, proportional gain = 2^KP_SHIFT
- KI_SHIFT, 6, integral term = integrator >>> KI_SHIFT (arithmetic)
- INT_W, 24, integrator width (signed)
- LOCK_TOL, 2, max |error| counted as in-lock
- LOCK_COUNT, 4, consecutive in-lock windows required to assert o_locked

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous reset, active-high
- i_enable  input  1  loop enable
- i_dco_tick  input  1  one-cycle pulse per DCO period, already synchronised to i_clk
- i_target  input  16  unsigned target tick count per window
- o_dco_enable  output  1  drives DCO enable
- o_control  output  16  signed control word to DCO
- o_valid  output  1  one-cycle pulse when o_control updates
- o_error  output  17  signed last window error
- o_locked  output  1  frequency lock indicator

Behaviour:
- Reset (i_rst=1 at posedge):
  - State IDLE.
  - All outputs 0; integrator, window counter, tick counter and lock counter all 0.
  - i_rst has priority over everything.
- FSM states:
  - IDLE -> COUNT when i_enable=1.
  - COUNT -> UPDATE after 2^WINDOW_LOG2 cycles.
  - UPDATE -> COUNT if i_enable=1, else IDLE.
  - Any state -> IDLE on the cycle after i_enable=0 is sampled.
- IDLE:
  - o_dco_enable=0, o_control=0, o_locked=0, o_valid=0.
  - Integrator and lock counter cleared.
  - o_error holds its last value.
- COUNT:
  - o_dco_enable=1.
  - Window counter runs 0..2^WINDOW_LOG2-1.
  - Tick counter increments on each i_dco_tick and saturates at 0xFFFF.
  - Entering COUNT from IDLE clears the tick counter.
- UPDATE (one cycle), computed combinationally, registered at the end of the cycle:
  - e = {0,i_target} - {0,count}, 17-bit signed.
  - i_target is sampled only in UPDATE.
  - Integrator update (anti-windup, based on the currently registered o_control):
    - If o_control==32767 and e>0: hold.
    - If o_control==-32768 and e<0: hold.
    - Otherwise integ_next = integ + e, saturated to the signed INT_W range.
  - sum = (e <<< KP_SHIFT) + (integ_next >>> KI_SHIFT), computed at INT_W+2 bits.
  - o_control = sum saturated to [-32768, 32767].
  - o_error = e; o_valid=1 for exactly that one cycle.
  - A tick arriving during UPDATE is counted into the next window: the tick counter loads 1, else 0.
- Timing:
  - Update period = 2^WINDOW_LOG2 + 1 cycles.
  - New o_control is visible on the first cycle of the following window.
  - First o_valid occurs 2^WINDOW_LOG2 + 1 cycles after the first COUNT cycle.
- Lock:
  - In UPDATE, if |e| <= LOCK_TOL, the lock counter increments (saturating at LOCK_COUNT).
  - Otherwise the lock counter clears and o_locked=0 in that same registered update.
  - o_locked=1 when the lock counter reaches LOCK_COUNT.
- i_enable drop mid-window:
  - Next cycle is IDLE: o_dco_enable=0, o_control=0, o_locked=0.
  - No o_valid pulse; the partial count is discarded.
- i_target changes mid-window have no effect until UPDATE.

Test Plan:
- Use WINDOW_LOG2=4 (16-cycle window) for all tests; other parameters at default.
1. Reset: assert i_rst mid-COUNT -> next cycle all outputs 0, state IDLE; i_enable still high -> COUNT resumes the cycle after i_rst releases.
2. Matched frequency: target 8, tick every 2nd cycle -> o_valid every 17 cycles, o_error=0, o_control=0, o_locked=1 at the 4th o_valid.
3. Slow DCO: target 8, no ticks -> 1st update o_error=8, o_control=32; 8th update integ=64, o_control=33.
4. Saturation/anti-windup: target 0xFFFF, no ticks -> o_control=32767 from the 1st update, integrator held at 65535. Then target 0, no ticks -> e=0, o_control=1023.
5. Lock loss: reach o_locked=1 (as in test 2), then one window of 5 ticks with target 8 -> o_error=3, o_locked=0 in the same update; 4 matched windows re-lock.
6. Enable drop: deassert i_enable at window cycle 7 -> next cycle o_dco_enable=0, o_control=0, o_locked=0, no o_valid. Re-enable -> first o_valid 17 cycles after COUNT entry, integrator restarted from 0.

Source files
------------

// File: rtl/tt_fll_ctrl.sv
// Frequency-locked-loop controller for a ring-oscillator DCO.
// The block counts DCO ticks over a fixed window of i_clk cycles and compares
// the count with a programmable target. A saturating PI update runs on the
// error and drives a signed control word, where 0 selects the DCO mid-range.
module tt_fll_ctrl #(
    parameter int WINDOW_LOG2 = 10,
    parameter int KP_SHIFT    = 2,
    parameter int KI_SHIFT    = 6,
    parameter int INT_W       = 24,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_dco_tick,
    input  logic [15:0] i_target,
    output logic        o_dco_enable,
    output logic [15:0] o_control,
    output logic        o_valid,
    output logic [16:0] o_error,
    output logic        o_locked
);

    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST  = '1;
    localparam logic [LC_W-1:0]        LOCK_FULL = LC_W'(LOCK_COUNT);
    localparam logic signed [16:0]     TOL_POS   = 17'(LOCK_TOL);
    localparam logic signed [16:0]     TOL_NEG   = -TOL_POS;
    localparam logic signed [INT_W:0]  INT_MAX_X = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W:0]  INT_MIN_X = {2'b11, {(INT_W-1){1'b0}}};
    localparam logic signed [INT_W+1:0] CTL_MAX_X = {{(INT_W-13){1'b0}}, 15'h7FFF};
    localparam logic signed [INT_W+1:0] CTL_MIN_X = {{(INT_W-13){1'b1}}, 15'h0000};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Clamp a one-bit-wider sum into the signed integrator range.
    function automatic logic [INT_W-1:0] sat_integ(input logic signed [INT_W:0] v);
        logic [INT_W-1:0] r;
        if (v > INT_MAX_X) begin
            r = INT_MAX_X[INT_W-1:0];
        end else if (v < INT_MIN_X) begin
            r = INT_MIN_X[INT_W-1:0];
        end else begin
            r = v[INT_W-1:0];
        end
        return r;
    endfunction

    // Clamp the PI sum into the signed 16-bit control range.
    function automatic logic [15:0] sat_ctrl(input logic signed [INT_W+1:0] v);
        logic [15:0] r;
        if (v > CTL_MAX_X) begin
            r = CTL_MAX_X[15:0];
        end else if (v < CTL_MIN_X) begin
            r = CTL_MIN_X[15:0];
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    state_t                   state_r, state_s;
    logic [WINDOW_LOG2-1:0]   win_cnt_r, win_cnt_s;
    logic [15:0]              tick_cnt_r, tick_cnt_s;
    logic signed [INT_W-1:0]  integ_r, integ_s;
    logic [LC_W-1:0]          lock_cnt_r, lock_cnt_s;
    logic                     dco_en_s, valid_s, locked_s;
    logic [15:0]              control_s;
    logic [16:0]              error_s;

    // PI datapath, only consumed in the UPDATE cycle.
    logic signed [16:0]       err_s;
    logic signed [INT_W:0]    integ_sum_s;
    logic                     hold_s;
    logic signed [INT_W-1:0]  integ_next_s;
    logic signed [INT_W-1:0]  integ_shr_s;
    logic signed [INT_W+1:0]  err_kp_s;
    logic signed [INT_W+1:0]  pi_sum_s;
    logic [15:0]              ctrl_sat_s;
    logic                     in_tol_s;
    logic [LC_W-1:0]          lock_next_s;

    assign err_s        = $signed({1'b0, i_target}) - $signed({1'b0, tick_cnt_r});
    assign integ_sum_s  = {integ_r[INT_W-1], integ_r} + {{(INT_W-16){err_s[16]}}, err_s};
    // Anti-windup: stop integrating further into a rail the output already sits on.
    assign hold_s       = ((o_control == 16'h7FFF) && (err_s > 17'sd0)) ||
                          ((o_control == 16'h8000) && (err_s < 17'sd0));
    assign integ_next_s = hold_s ? integ_r : sat_integ(integ_sum_s);
    assign integ_shr_s  = integ_next_s >>> KI_SHIFT;
    assign err_kp_s     = {{(INT_W-15){err_s[16]}}, err_s} <<< KP_SHIFT;
    assign pi_sum_s     = err_kp_s + {{2{integ_shr_s[INT_W-1]}}, integ_shr_s};
    assign ctrl_sat_s   = sat_ctrl(pi_sum_s);
    assign in_tol_s     = (err_s <= TOL_POS) && (err_s >= TOL_NEG);
    assign lock_next_s  = in_tol_s ? ((lock_cnt_r == LOCK_FULL) ? lock_cnt_r
                                                                : lock_cnt_r + LC_W'(1))
                                   : '0;

    // Next-state and next-output logic; dropping i_enable overrides every state.
    always_comb begin
        state_s    = state_r;
        win_cnt_s  = win_cnt_r;
        tick_cnt_s = tick_cnt_r;
        integ_s    = integ_r;
        lock_cnt_s = lock_cnt_r;
        dco_en_s   = 1'b0;
        control_s  = o_control;
        valid_s    = 1'b0;
        error_s    = o_error;
        locked_s   = o_locked;
        if (!i_enable) begin
            state_s    = ST_IDLE;
            win_cnt_s  = '0;
            tick_cnt_s = 16'h0000;
            integ_s    = '0;
            lock_cnt_s = '0;
            control_s  = 16'h0000;
            locked_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s    = ST_COUNT;
                    win_cnt_s  = '0;
                    tick_cnt_s = 16'h0000;
                    dco_en_s   = 1'b1;
                end
                ST_COUNT: begin
                    dco_en_s = 1'b1;
                    if (i_dco_tick && (tick_cnt_r != 16'hFFFF)) begin
                        tick_cnt_s = tick_cnt_r + 16'd1;
                    end else begin
                        tick_cnt_s = tick_cnt_r;
                    end
                    if (win_cnt_r == WIN_LAST) begin
                        state_s   = ST_UPDATE;
                        win_cnt_s = '0;
                    end else begin
                        state_s   = ST_COUNT;
                        win_cnt_s = win_cnt_r + WINDOW_LOG2'(1);
                    end
                end
                ST_UPDATE: begin
                    state_s    = ST_COUNT;
                    dco_en_s   = 1'b1;
                    integ_s    = integ_next_s;
                    control_s  = ctrl_sat_s;
                    error_s    = err_s;
                    valid_s    = 1'b1;
                    lock_cnt_s = lock_next_s;
                    locked_s   = (lock_next_s == LOCK_FULL);
                    // A tick landing in the update cycle belongs to the next window.
                    tick_cnt_s = i_dco_tick ? 16'd1 : 16'd0;
                end
                default: begin
                    state_s    = ST_IDLE;
                    win_cnt_s  = '0;
                    tick_cnt_s = 16'h0000;
                    integ_s    = '0;
                    lock_cnt_s = '0;
                    control_s  = 16'h0000;
                    locked_s   = 1'b0;
                end
            endcase
        end
    end

    // State, loop and output registers with synchronous reset priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            win_cnt_r    <= '0;
            tick_cnt_r   <= 16'h0000;
            integ_r      <= '0;
            lock_cnt_r   <= '0;
            o_dco_enable <= 1'b0;
            o_control    <= 16'h0000;
            o_valid      <= 1'b0;
            o_error      <= 17'h00000;
            o_locked     <= 1'b0;
        end else begin
            state_r      <= state_s;
            win_cnt_r    <= win_cnt_s;
            tick_cnt_r   <= tick_cnt_s;
            integ_r      <= integ_s;
            lock_cnt_r   <= lock_cnt_s;
            o_dco_enable <= dco_en_s;
            o_control    <= control_s;
            o_valid      <= valid_s;
            o_error      <= error_s;
            o_locked     <= locked_s;
        end
    end

endmodule

// File: tb/tb_tt_fll_ctrl.sv
// Directed bench for tt_fll_ctrl with a 16-cycle window.
// A window-level model computes every expected output, and a per-cycle
// compare process checks the DUT against it. Literal checks pin known values.
module tb_tt_fll_ctrl;

    localparam int WIN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic [15:0] target;
    logic        o_dco_enable;
    logic [15:0] o_control;
    logic        o_valid;
    logic [16:0] o_error;
    logic        o_locked;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_mode = 0;

    // Model state: window position and accumulated loop quantities
    bit m_active = 1'b0;
    int m_pos = 0;
    int m_ticks = 0;
    int m_integ = 0;
    int m_lock = 0;
    int e_den = 0, e_ctrl = 0, e_valid = 0, e_err = 0, e_locked = 0;
    bit started = 1'b0;

    tt_fll_ctrl #(.WINDOW_LOG2(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_dco_tick(tick), .i_target(target),
        .o_dco_enable(o_dco_enable), .o_control(o_control), .o_valid(o_valid),
        .o_error(o_error), .o_locked(o_locked)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Tick pattern by position in the window; position WIN is the update cycle.
    function automatic logic gen_tick(input int mode, input bit act, input int pos);
        if (!act) return 1'b0;
        case (mode)
            1: return (pos < WIN) && (pos % 2 == 0);
            2: return pos < 5;
            3: return pos % 4 == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Tick driver, a little after each rising edge
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tick = gen_tick(tick_mode, m_active, m_pos);
        end
    end

    // Model advance at each edge, and a full output compare 1 ns later
    initial begin
        bit r, e, t;
        int tg, err, ni, sum;
        forever begin
            @(posedge clk);
            r = rst; e = en; t = tick; tg = int'(target);
            if (r) begin
                started = 1'b1;
                m_active = 1'b0; m_pos = 0; m_ticks = 0; m_integ = 0; m_lock = 0;
                e_den = 0; e_ctrl = 0; e_valid = 0; e_err = 0; e_locked = 0;
            end else if (!e) begin
                m_active = 1'b0; m_pos = 0; m_ticks = 0; m_integ = 0; m_lock = 0;
                e_den = 0; e_ctrl = 0; e_valid = 0; e_locked = 0;
            end else if (!m_active) begin
                m_active = 1'b1; m_pos = 0; m_ticks = 0;
                e_den = 1; e_valid = 0;
            end else if (m_pos < WIN) begin
                if (t) m_ticks = clamp(m_ticks + 1, 0, 65535);
                m_pos++;
                e_den = 1; e_valid = 0;
            end else begin
                err = tg - m_ticks;
                if ((e_ctrl == 32767 && err > 0) || (e_ctrl == -32768 && err < 0))
                    ni = m_integ;
                else
                    ni = clamp(m_integ + err, -(1 << 23), (1 << 23) - 1);
                m_integ = ni;
                sum = err * 4 + (ni >>> 6);
                e_ctrl = clamp(sum, -32768, 32767);
                e_err = err;
                e_valid = 1;
                e_den = 1;
                m_lock = (err <= 2 && err >= -2) ? clamp(m_lock + 1, 0, 4) : 0;
                e_locked = (m_lock == 4) ? 1 : 0;
                m_ticks = t ? 1 : 0;
                m_pos = 0;
            end
            #1;
            if (started) begin
                chk("cyc_dco_enable", {31'd0, o_dco_enable}, e_den);
                chk("cyc_control", $signed(o_control), e_ctrl);
                chk("cyc_valid", {31'd0, o_valid}, e_valid);
                chk("cyc_error", $signed(o_error), e_err);
                chk("cyc_locked", {31'd0, o_locked}, e_locked);
            end
        end
    end

    // Wait (bounded) for the next o_valid; n is negedges waited
    task automatic wait_valid(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            n++;
            if (o_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_valid at %0t: no o_valid within 40 cycles", $time);
        end
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; target = 16'd0;
        repeat (3) @(negedge clk);

        // Reset mid-COUNT with enable held high
        rst = 1'b0; en = 1'b1; target = 16'd8; tick_mode = 1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_dco_enable", {31'd0, o_dco_enable}, 0);
        chk("rst_control", $signed(o_control), 0);
        chk("rst_error", $signed(o_error), 0);
        chk("rst_valid", {31'd0, o_valid}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("resume_dco_enable", {31'd0, o_dco_enable}, 1);

        // Matched frequency: lock on the 4th update
        for (int k = 1; k <= 4; k++) begin
            wait_valid(n);
            chk("match_error", $signed(o_error), 0);
            chk("match_control", $signed(o_control), 0);
            chk("match_locked", {31'd0, o_locked}, (k == 4) ? 1 : 0);
        end

        // Lock loss: one window with 5 ticks, then re-lock
        tick_mode = 2;
        wait_valid(n);
        chk("loss_error", $signed(o_error), 3);
        chk("loss_locked", {31'd0, o_locked}, 0);
        tick_mode = 1;
        for (int k = 1; k <= 4; k++) begin
            wait_valid(n);
            chk("relock_locked", {31'd0, o_locked}, (k == 4) ? 1 : 0);
        end

        // Slow DCO: no ticks, target 8; mid-window target changes ignored
        en = 1'b0; tick_mode = 0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_valid(n);
            if (k == 1) begin
                chk("slow_err1", $signed(o_error), 8);
                chk("slow_ctrl1", $signed(o_control), 32);
            end
            if (k == 3) chk("slow_err3", $signed(o_error), 8);
            if (k == 8) chk("slow_ctrl8", $signed(o_control), 33);
            if (k == 2) begin
                target = 16'd100;
                repeat (5) @(negedge clk);
                target = 16'd8;
            end
        end

        // Saturation and anti-windup
        en = 1'b0; target = 16'hFFFF;
        repeat (2) @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_valid(n);
            chk("sat_ctrl", $signed(o_control), 32767);
        end
        chk("sat_error", $signed(o_error), 65535);
        target = 16'd0;
        wait_valid(n);
        chk("unwind_error", $signed(o_error), 0);
        chk("unwind_ctrl", $signed(o_control), 1023);

        // Tick in the update cycle carries into the next window
        en = 1'b0; tick_mode = 3; target = 16'd5;
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_valid(n);
        chk("carry_err1", $signed(o_error), 1);
        wait_valid(n);
        chk("carry_err2", $signed(o_error), 0);
        wait_valid(n);

        // Enable drop at window cycle 7, then re-enable
        en = 1'b0; tick_mode = 0; target = 16'd8;
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_valid(n);
        chk("drop_pre_ctrl", $signed(o_control), 32);
        repeat (7) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("drop_dco_enable", {31'd0, o_dco_enable}, 0);
        chk("drop_control", $signed(o_control), 0);
        chk("drop_locked", {31'd0, o_locked}, 0);
        chk("drop_valid", {31'd0, o_valid}, 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_valid(n);
        chk("reenable_latency", n, 18);
        chk("reenable_ctrl", $signed(o_control), 32);

        en = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
